udp_pkt_queue: RTL and testbench

- Packet-level store-and-forward queue between the UDP receive path and the UDP transmit path of the UDP loopback design.
- Buffers received 32-bit payload words and commits each packet only once it has been received in full. A bad or overflowing packet is rolled back.
- Starts one UDP transmit per committed packet, only when the transmitter is idle and not inhibited. Supplies the payload words and the byte count to the transmitter.
- Replaces the direct "rec_pkt_done starts tx" coupling, so back-to-back packets queue instead of being lost.

---
 rtl/eth_udp_pkg.sv | 21 ++
 rtl/udp_pkt_ram.sv | 33 +++
 rtl/udp_pkt_queue.sv | 188 ++++++++++++++++++
 tb/tb_udp_pkt_queue.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_udp_pkg.sv
// Shared constants, the word-count helper and the transmit FSM state type
// used across the UDP loopback datapath.
package eth_udp_pkg;

  localparam int MAX_UDP_BYTES = 1472;
  localparam int WORD_BYTES    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } tx_state_e;

  // Number of 32-bit words needed to hold n payload bytes. Widened to 17 bits
  // so that n = 16'hffff does not wrap before the shift.
  function automatic logic [16:0] words(input logic [15:0] n);
    return ({1'b0, n} + 17'(WORD_BYTES - 1)) >> 2;
  endfunction

endpackage

// File: rtl/udp_pkt_ram.sv
// Simple dual-port payload RAM: one write port, one registered read port with
// read enable so the output holds its value between reads.
module udp_pkt_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  // Storage array, written without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register; reset so the transmit data output starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/udp_pkt_queue.sv
// Packet-level store-and-forward queue between UDP receive and UDP transmit.
// Words are buffered as they arrive and a packet is committed only when its
// final length checks out; otherwise the write pointer rolls back. Committed
// packets are handed to the transmitter one at a time.
//
// TX FSM states:
//   state | meaning
//   IDLE  | waiting for a committed packet and tx_hold low
//   START | tx_start_en pulse out, byte count presented, timer armed
//   WAIT  | serving tx_req reads until tx_done or watchdog expiry
//   GAP   | one spacer cycle so tx_done and the next start never touch
module udp_pkt_queue
  import eth_udp_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int PKT_AW    = 4,
  parameter int MAX_BYTES = MAX_UDP_BYTES,
  parameter int TO_CYC    = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rec_en,
  input  logic [31:0]       rec_data,
  input  logic              rec_pkt_done,
  input  logic [15:0]       rec_byte_num,
  input  logic              tx_hold,
  input  logic              tx_req,
  input  logic              tx_done,
  output logic              tx_start_en,
  output logic [15:0]       tx_byte_num,
  output logic [31:0]       tx_data,
  output logic              pkt_drop,
  output logic [PKT_AW:0]   pkt_cnt
);

  localparam logic [ADDR_W:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};
  localparam int              PKT_DEPTH = 2**PKT_AW;
  localparam logic [15:0]     TO_LAST = 16'(TO_CYC - 1);

  // Write side
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, wr_base_q, wr_base_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic              ovf_q, ovf_d;
  logic              pkt_drop_q, pkt_drop_d;
  logic [ADDR_W:0]   used, wcnt_eff, wr_ptr_eff;
  logic              space_full, wr_word, ovf_now, len_ok, lf_full, commit;

  // Length FIFO
  logic [15:0]       len_mem_q [PKT_DEPTH];
  logic [PKT_AW-1:0] lf_wr_q, lf_wr_d, lf_rd_q;
  logic [PKT_AW:0]   pkt_cnt_q, pkt_cnt_d;

  // Read side
  tx_state_e         state_q;
  logic              tx_start_en_q;
  logic [15:0]       tx_byte_num_q;
  logic [16:0]       rcnt_q, tx_words;
  logic [15:0]       timer_q;
  logic [ADDR_W:0]   rd_ptr_q;
  logic              rd_fire, tx_pop;
  logic [ADDR_W-1:0] rd_addr;

  assign tx_words = words(tx_byte_num_q);
  assign rd_fire  = (state_q == WAIT) && tx_req && (rcnt_q < tx_words);
  assign tx_pop   = (state_q == WAIT) && (tx_done || (timer_q == 16'd0));
  assign rd_addr  = rd_ptr_q[ADDR_W-1:0] + rcnt_q[ADDR_W-1:0];

  // Write-side bookkeeping and the commit/rollback decision.
  always_comb begin
    used       = wr_ptr_q - rd_ptr_q;
    space_full = (used == DEPTH_P);
    wr_word    = rec_en && !ovf_q && !space_full;
    ovf_now    = ovf_q || (rec_en && space_full);
    wcnt_eff   = wcnt_q + (ADDR_W+1)'(wr_word);
    wr_ptr_eff = wr_ptr_q + (ADDR_W+1)'(wr_word);
    len_ok     = (rec_byte_num != 16'd0) && (rec_byte_num <= 16'(MAX_BYTES));
    lf_full    = (pkt_cnt_q == (PKT_AW+1)'(PKT_DEPTH));
    commit     = rec_pkt_done && !ovf_now && len_ok && !lf_full &&
                 (17'(wcnt_eff) == words(rec_byte_num));

    wr_ptr_d   = wr_ptr_eff;
    wr_base_d  = wr_base_q;
    wcnt_d     = wcnt_eff;
    ovf_d      = ovf_now;
    pkt_drop_d = 1'b0;
    if (rec_pkt_done) begin
      wcnt_d = '0;
      ovf_d  = 1'b0;
      if (commit) begin
        wr_base_d = wr_ptr_eff;
      end else begin
        wr_ptr_d   = wr_base_q;
        pkt_drop_d = 1'b1;
      end
    end

    lf_wr_d   = lf_wr_q + PKT_AW'(commit);
    pkt_cnt_d = pkt_cnt_q + (PKT_AW+1)'(commit) - (PKT_AW+1)'(tx_pop);
  end

  // Write-side and FIFO occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      wr_base_q  <= '0;
      wcnt_q     <= '0;
      ovf_q      <= 1'b0;
      pkt_drop_q <= 1'b0;
      lf_wr_q    <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      wr_base_q  <= wr_base_d;
      wcnt_q     <= wcnt_d;
      ovf_q      <= ovf_d;
      pkt_drop_q <= pkt_drop_d;
      lf_wr_q    <= lf_wr_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  // Length FIFO storage; entries are only meaningful behind pkt_cnt.
  always_ff @(posedge clk) begin
    if (commit) len_mem_q[lf_wr_q] <= rec_byte_num;
  end

  // Transmit FSM. rd_ptr advances by the packet's full word count on exit,
  // whatever was actually read, so a short or timed-out transmit resyncs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tx_start_en_q <= 1'b0;
      tx_byte_num_q <= '0;
      rcnt_q        <= '0;
      timer_q       <= '0;
      rd_ptr_q      <= '0;
      lf_rd_q       <= '0;
    end else begin
      tx_start_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((pkt_cnt_q != '0) && !tx_hold) begin
            state_q       <= START;
            tx_start_en_q <= 1'b1;
            tx_byte_num_q <= len_mem_q[lf_rd_q];
          end
        end
        START: begin
          rcnt_q  <= '0;
          timer_q <= TO_LAST;
          state_q <= WAIT;
        end
        WAIT: begin
          if (rd_fire) rcnt_q <= rcnt_q + 17'd1;
          if (tx_pop) begin
            rd_ptr_q <= rd_ptr_q + tx_words[ADDR_W:0];
            lf_rd_q  <= lf_rd_q + PKT_AW'(1);
            state_q  <= GAP;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  udp_pkt_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_word),
    .wr_addr (wr_ptr_q[ADDR_W-1:0]),
    .wr_data (rec_data),
    .rd_en   (rd_fire),
    .rd_addr (rd_addr),
    .rd_data (tx_data)
  );

  assign tx_start_en = tx_start_en_q;
  assign tx_byte_num = tx_byte_num_q;
  assign pkt_drop    = pkt_drop_q;
  assign pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_udp_pkt_queue.sv
// Bench for udp_pkt_queue: table-driven packet vectors, directed corner
// sequences and randomized batches, all checked against a packet-level model
// (queue of committed byte counts plus a queue of their payload words).
module tb_udp_pkt_queue;

  localparam int TO = 50;
  localparam int DEPTH = 2048;
  localparam int PKTS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rec_en = 1'b0;
  logic [31:0] rec_data = '0;
  logic        rec_pkt_done = 1'b0;
  logic [15:0] rec_byte_num = '0;
  logic        tx_hold = 1'b0;
  logic        tx_req = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic [31:0] tx_data;
  logic        pkt_drop;
  logic [4:0]  pkt_cnt;

  int errors = 0;
  int checks = 0;

  int          exp_len[$];
  logic [31:0] exp_w[$];
  logic [31:0] last_data = '0;
  logic [31:0] pkt_buf [512];

  typedef struct {
    int bytes;
    int nw;
    bit same;
    bit drop;
    int cnt;
  } vec_t;
  vec_t tbl [9];

  udp_pkt_queue #(
    .ADDR_W(11), .PKT_AW(4), .MAX_BYTES(1472), .TO_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rec_en(rec_en), .rec_data(rec_data),
    .rec_pkt_done(rec_pkt_done), .rec_byte_num(rec_byte_num),
    .tx_hold(tx_hold), .tx_req(tx_req), .tx_done(tx_done),
    .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num), .tx_data(tx_data),
    .pkt_drop(pkt_drop), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int wds(input int b);
    return (b + 3) / 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit predict_commit(input int b, input int n);
    if (n > DEPTH - exp_w.size()) return 1'b0;
    if (b < 1 || b > 1472) return 1'b0;
    if (n != wds(b)) return 1'b0;
    if (exp_len.size() >= PKTS) return 1'b0;
    return 1'b1;
  endfunction

  task automatic send_pkt(input int b, input int n, input bit same, input bit rnd,
                          output bit drop_seen);
    bit ec;
    ec = predict_commit(b, n);
    if (rnd) begin
      for (int i = 0; i < n; i++) pkt_buf[i] = $urandom();
      if (n > 0 && n == wds(b) && (b % 4) != 0)
        pkt_buf[n-1] = pkt_buf[n-1] & (32'hffff_ffff << (8 * (4 - b % 4)));
    end
    for (int i = 0; i < n; i++) begin
      rec_en   = 1'b1;
      rec_data = pkt_buf[i];
      if (same && i == n - 1) begin
        rec_pkt_done = 1'b1;
        rec_byte_num = 16'(b);
      end
      tick();
    end
    rec_en   = 1'b0;
    rec_data = '0;
    if (!(same && n > 0)) begin
      rec_pkt_done = 1'b1;
      rec_byte_num = 16'(b);
      tick();
    end
    rec_pkt_done = 1'b0;
    rec_byte_num = '0;
    drop_seen = pkt_drop;
    chk("pkt_drop", {31'd0, pkt_drop}, {31'd0, !ec});
    if (ec) begin
      exp_len.push_back(b);
      for (int i = 0; i < n; i++) exp_w.push_back(pkt_buf[i]);
    end
    chk("pkt_cnt_rx", {27'd0, pkt_cnt}, exp_len.size());
  endtask

  // Acts as the UDP transmitter for one packet: waits for the start pulse,
  // pulls nreq words, then signals tx_done.
  task automatic serve_one(input int nreq, input bit gap_chk, output int lat);
    int w;
    lat = 0;
    while (!tx_start_en && lat < 300) begin
      tick();
      lat++;
    end
    if (!tx_start_en) begin
      chk("start_timeout", {31'd0, tx_start_en}, 32'd1);
      exp_len.delete();
      exp_w.delete();
      return;
    end
    if (gap_chk) chk("start_gap", {31'd0, lat >= 2}, 32'd1);
    chk("tx_byte_num", {16'd0, tx_byte_num}, exp_len[0]);
    w = wds(exp_len[0]);
    tick();
    chk("start_pulse", {31'd0, tx_start_en}, 32'd0);
    for (int i = 0; i < nreq; i++) begin
      tx_req = 1'b1;
      tick();
      if (i < w) last_data = exp_w[i];
      chk("tx_data", tx_data, last_data);
    end
    tx_req  = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    void'(exp_len.pop_front());
    repeat (w) void'(exp_w.pop_front());
    chk("pkt_cnt_pop", {27'd0, pkt_cnt}, exp_len.size());
  endtask

  task automatic serve_all(input int maxreq);
    int lat, w, nreq;
    bit first;
    first = 1'b1;
    tx_hold = 1'b0;
    while (exp_len.size() > 0) begin
      w = wds(exp_len[0]);
      nreq = (w + 1 < maxreq) ? w + 1 : maxreq;
      serve_one(nreq, !first, lat);
      first = 1'b0;
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_start"}, {31'd0, tx_start_en}, 32'd0);
    chk({tag, "_bytes"}, {16'd0, tx_byte_num}, 32'd0);
    chk({tag, "_data"}, tx_data, 32'd0);
    chk({tag, "_drop"}, {31'd0, pkt_drop}, 32'd0);
    chk({tag, "_cnt"}, {27'd0, pkt_cnt}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    rec_en = 1'b0; rec_pkt_done = 1'b0; tx_req = 1'b0; tx_done = 1'b0;
    #1;
    rst_chk(tag);
    tick();
    rst_n = 1'b1;
    exp_len.delete();
    exp_w.delete();
    last_data = '0;
    tick();
  endtask

  initial begin
    bit d;
    int lat, n, mode, b, nw, bat;
    bit bad;

    tbl[0] = '{10,   3,   1'b1, 1'b0, 1};
    tbl[1] = '{9,    2,   1'b1, 1'b1, 1};
    tbl[2] = '{4,    1,   1'b0, 1'b0, 2};
    tbl[3] = '{0,    0,   1'b0, 1'b1, 2};
    tbl[4] = '{1473, 369, 1'b1, 1'b1, 2};
    tbl[5] = '{1472, 368, 1'b0, 1'b0, 3};
    tbl[6] = '{8,    3,   1'b1, 1'b1, 3};
    tbl[7] = '{1,    1,   1'b1, 1'b0, 4};
    tbl[8] = '{13,   3,   1'b0, 1'b1, 4};

    // Reset state
    #2;
    rst_chk("rst0");
    tick();
    rst_n = 1'b1;
    tick();

    // Single 10-byte packet, start latency and word order
    pkt_buf[0] = 32'h1111_1111;
    pkt_buf[1] = 32'h2222_2222;
    pkt_buf[2] = 32'h3333_0000;
    send_pkt(10, 3, 1'b1, 1'b0, d);
    chk("t1_no_early_start", {31'd0, tx_start_en}, 32'd0);
    serve_one(3, 1'b0, lat);
    chk("t1_start_lat", lat, 32'd1);

    // Table-driven commit/drop vectors, transmitter held off
    tx_hold = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send_pkt(tbl[i].bytes, tbl[i].nw, tbl[i].same, 1'b1, d);
      chk("tbl_drop", {31'd0, d}, {31'd0, tbl[i].drop});
      chk("tbl_cnt", {27'd0, pkt_cnt}, tbl[i].cnt);
    end
    serve_all(20);

    // Three back-to-back 64-byte packets queued behind a busy transmitter
    tx_hold = 1'b1;
    repeat (3) send_pkt(64, 16, 1'b1, 1'b1, d);
    chk("b2b_cnt", {27'd0, pkt_cnt}, 32'd3);
    serve_all(17);

    // Fill to 2040 words, then a 16-word packet overflows; resend after drain
    tx_hold = 1'b1;
    repeat (5) send_pkt(1472, 368, 1'b1, 1'b1, d);
    send_pkt(800, 200, 1'b0, 1'b1, d);
    send_pkt(64, 16, 1'b1, 1'b1, d);
    chk("ovf_drop", {31'd0, d}, 32'd1);
    serve_all(4);
    send_pkt(64, 16, 1'b1, 1'b0, d);
    chk("ovf_resend_ok", {31'd0, d}, 32'd0);
    serve_all(17);

    // Length FIFO full: 17th packet dropped
    tx_hold = 1'b1;
    repeat (16) send_pkt(4, 1, 1'b1, 1'b1, d);
    send_pkt(4, 1, 1'b1, 1'b1, d);
    chk("lf_full_drop", {31'd0, d}, 32'd1);
    serve_all(2);

    // tx_hold blocks start; release starts next cycle; watchdog expiry
    tx_hold = 1'b1;
    send_pkt(8, 2, 1'b1, 1'b1, d);
    bad = 1'b0;
    repeat (100) begin
      tick();
      if (tx_start_en) bad = 1'b1;
    end
    chk("hold_no_start", {31'd0, bad}, 32'd0);
    tx_hold = 1'b0;
    tick();
    chk("hold_release_start", {31'd0, tx_start_en}, 32'd1);
    n = 0;
    while (pkt_cnt != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, TO + 1);
    void'(exp_len.pop_front());
    repeat (2) void'(exp_w.pop_front());
    send_pkt(12, 3, 1'b0, 1'b1, d);
    serve_all(4);

    // Randomized batches
    for (int it = 0; it < 25; it++) begin
      tx_hold = 1'b1;
      bat = $urandom_range(1, 4);
      for (int p = 0; p < bat; p++) begin
        mode = $urandom_range(0, 9);
        if (mode == 0) begin
          b = 0; nw = $urandom_range(0, 2);
        end else if (mode == 1) begin
          b = 1473 + $urandom_range(0, 50); nw = $urandom_range(1, 3);
        end else if (mode == 2) begin
          b = $urandom_range(1, 120);
          nw = $urandom_range(0, 1) ? wds(b) + 1 : wds(b) - 1;
        end else begin
          b = $urandom_range(1, 120); nw = wds(b);
        end
        send_pkt(b, nw, 1'(($urandom_range(0, 1))), 1'b1, d);
      end
      serve_all($urandom_range(0, 32));
    end

    // Reset mid-receive with a packet already queued
    tx_hold = 1'b1;
    send_pkt(8, 2, 1'b1, 1'b1, d);
    for (int i = 0; i < 3; i++) begin
      rec_en = 1'b1;
      rec_data = $urandom();
      tick();
    end
    do_reset("rst_rx");
    tx_hold = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (tx_start_en) bad = 1'b1;
    end
    chk("rst_rx_no_start", {31'd0, bad}, 32'd0);
    chk("rst_rx_cnt", {27'd0, pkt_cnt}, 32'd0);

    // Reset mid-transmit
    send_pkt(32, 8, 1'b1, 1'b1, d);
    n = 0;
    while (!tx_start_en && n < 20) begin
      tick();
      n++;
    end
    chk("rst_tx_started", {31'd0, tx_start_en}, 32'd1);
    tick();
    tx_req = 1'b1;
    tick();
    tick();
    tx_req = 1'b0;
    chk("rst_tx_word1", tx_data, pkt_buf[1]);
    do_reset("rst_tx");
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (tx_start_en) bad = 1'b1;
    end
    chk("rst_tx_no_start", {31'd0, bad}, 32'd0);
    send_pkt(20, 5, 1'b1, 1'b1, d);
    serve_all(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
